// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage for the 16-bit WISC pipeline.
// Holds one decoded instruction behind a valid/ready handshake. It also
// handles sticky HALT/illegal-opcode state, load-use stalls and flush.
module decode_stage #(
   parameter int unsigned INSTR_W   = 16,
   parameter int unsigned PC_W      = 16,
   parameter logic        HAZARD_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [19:0]        out_ctrl,
   output logic [2:0]         out_wr_addr,
   output logic               halted,
   output logic               err,
   output logic [PC_W-1:0]    err_pc
);

   // Control bundle; field order gives the packed MSB->LSB layout of out_ctrl.
   typedef struct packed {
      logic       halt;
      logic       jump;
      logic       branch;
      logic       mem_rd_en;
      logic       reg_wr_sel;
      logic       mem_wr_en;
      logic       alu_src_sel;
      logic       reg_wr_en;
      logic       extend_sign;
      logic       data1_sel;
      logic       r7_sel;
      logic [1:0] reg_des_sel;
      logic [1:0] jri_sel;
      logic [4:0] alu_op;
   } ctrl_t;

   // Instruction fields of the incoming word
   logic [4:0] w_op;
   logic [2:0] w_rs;
   logic [2:0] w_rt;
   logic [2:0] w_rd;

   assign w_op = in_instr[INSTR_W-1 -: 5];
   assign w_rs = in_instr[10:8];
   assign w_rt = in_instr[7:5];
   assign w_rd = in_instr[4:2];

   // Pipeline register contents
   logic               r_valid;
   logic [INSTR_W-1:0] r_instr;
   logic [PC_W-1:0]    r_pc;
   ctrl_t              r_ctrl;
   logic [2:0]         r_wr_addr;
   logic               r_halted;
   logic               r_err;
   logic [PC_W-1:0]    r_err_pc;

   // Combinational decode results
   ctrl_t      w_dec;
   logic       w_illegal;
   logic       w_rs_used;
   logic       w_rt_used;
   logic [2:0] w_wr_addr;
   logic       w_stall;
   logic       w_accept;

   // Opcode decode: every field is assigned for every opcode
   always_comb begin
      w_dec           = '0;
      w_dec.alu_op    = w_op;
      w_dec.data1_sel = 1'b1;
      w_illegal       = 1'b0;
      casez (w_op)
         5'b00000: begin                         // HALT
            w_dec.halt      = 1'b1;
            w_dec.data1_sel = 1'b0;
         end
         5'b00001: begin                         // NOP
            w_dec.data1_sel = 1'b0;
         end
         5'b0001?: begin                         // reserved
            w_illegal = 1'b1;
         end
         5'b00100: begin                         // J
            w_dec.branch      = 1'b1;
            w_dec.jri_sel     = 2'b10;
            w_dec.extend_sign = 1'b1;
            w_dec.data1_sel   = 1'b0;
         end
         5'b00101: begin                         // JR
            w_dec.jump        = 1'b1;
            w_dec.alu_src_sel = 1'b1;
            w_dec.jri_sel     = 2'b01;
            w_dec.extend_sign = 1'b1;
         end
         5'b00110: begin                         // JAL
            w_dec.reg_des_sel = 2'b10;
            w_dec.branch      = 1'b1;
            w_dec.reg_wr_en   = 1'b1;
            w_dec.jri_sel     = 2'b10;
            w_dec.extend_sign = 1'b1;
            w_dec.r7_sel      = 1'b1;
            w_dec.data1_sel   = 1'b0;
         end
         5'b00111: begin                         // JALR
            w_dec.reg_des_sel = 2'b10;
            w_dec.jump        = 1'b1;
            w_dec.alu_src_sel = 1'b1;
            w_dec.reg_wr_en   = 1'b1;
            w_dec.jri_sel     = 2'b01;
            w_dec.extend_sign = 1'b1;
            w_dec.r7_sel      = 1'b1;
         end
         5'b0100?: begin                         // ADDI / SUBI
            w_dec.reg_des_sel = 2'b01;
            w_dec.alu_src_sel = 1'b1;
            w_dec.reg_wr_en   = 1'b1;
            w_dec.extend_sign = 1'b1;
         end
         5'b0101?: begin                         // XORI / ANDNI
            w_dec.reg_des_sel = 2'b01;
            w_dec.alu_src_sel = 1'b1;
            w_dec.reg_wr_en   = 1'b1;
         end
         5'b011??: begin                         // conditional branches
            w_dec.branch      = 1'b1;
            w_dec.jri_sel     = 2'b01;
            w_dec.extend_sign = 1'b1;
         end
         5'b10000: begin                         // ST
            w_dec.mem_wr_en   = 1'b1;
            w_dec.alu_src_sel = 1'b1;
            w_dec.extend_sign = 1'b1;
            w_dec.reg_des_sel = 2'b11;
         end
         5'b10001: begin                         // LD
            w_dec.reg_des_sel = 2'b01;
            w_dec.mem_rd_en   = 1'b1;
            w_dec.reg_wr_sel  = 1'b1;
            w_dec.alu_src_sel = 1'b1;
            w_dec.reg_wr_en   = 1'b1;
            w_dec.extend_sign = 1'b1;
         end
         5'b10010: begin                         // SLBI
            w_dec.reg_des_sel = 2'b11;
            w_dec.alu_src_sel = 1'b1;
            w_dec.reg_wr_en   = 1'b1;
            w_dec.jri_sel     = 2'b01;
         end
         5'b10011: begin                         // STU
            w_dec.reg_des_sel = 2'b11;
            w_dec.mem_wr_en   = 1'b1;
            w_dec.alu_src_sel = 1'b1;
            w_dec.reg_wr_en   = 1'b1;
            w_dec.extend_sign = 1'b1;
         end
         5'b101??: begin                         // shift/rotate immediates
            w_dec.reg_des_sel = 2'b01;
            w_dec.alu_src_sel = 1'b1;
            w_dec.reg_wr_en   = 1'b1;
            w_dec.jri_sel     = 2'b11;
         end
         5'b11000: begin                         // LBI
            w_dec.reg_des_sel = 2'b11;
            w_dec.alu_src_sel = 1'b1;
            w_dec.reg_wr_en   = 1'b1;
            w_dec.jri_sel     = 2'b01;
            w_dec.extend_sign = 1'b1;
            w_dec.data1_sel   = 1'b0;
         end
         5'b11010: begin                         // reserved hole inside 1101x
            w_illegal = 1'b1;
         end
         5'b11001, 5'b11011, 5'b111??: begin     // BTR and R-type ALU ops
            w_dec.reg_des_sel = 2'b00;
            w_dec.reg_wr_en   = 1'b1;
            w_dec.jri_sel     = 2'b11;
         end
         default: begin
            w_illegal = 1'b0;
         end
      endcase
   end

   // Source-register usage of the incoming instruction, for hazard detection
   always_comb begin
      w_rs_used = 1'b1;
      w_rt_used = 1'b0;
      if (w_op == 5'b00000 || w_op == 5'b00001 || w_op == 5'b00100 ||
          w_op == 5'b00110 || w_op == 5'b11000) begin
         w_rs_used = 1'b0;
      end
      if (w_op[4:1] == 4'b1101 || w_op[4:2] == 3'b111 ||
          w_op == 5'b10000 || w_op == 5'b10011) begin
         w_rt_used = 1'b1;
      end
   end

   // Destination register select
   always_comb begin
      w_wr_addr = w_rd;
      case (w_dec.reg_des_sel)
         2'b00:   w_wr_addr = w_rd;
         2'b01:   w_wr_addr = w_rt;
         2'b10:   w_wr_addr = 3'd7;
         default: w_wr_addr = w_rs;
      endcase
   end

   // Load-use hazard: the held LD's result is not yet available to the new instruction
   assign w_stall = HAZARD_EN & in_valid & r_valid & r_ctrl.mem_rd_en & r_ctrl.reg_wr_en &
                    ((w_rs_used & (w_rs == r_wr_addr)) | (w_rt_used & (w_rt == r_wr_addr)));

   assign in_ready = rst_n & ~r_halted & ~r_err & ~flush & ~w_stall & (~r_valid | out_ready);
   assign w_accept = in_valid & in_ready;

   // Pipeline register with sticky halt/error tracking; flush wins over everything but reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_instr   <= '0;
         r_pc      <= '0;
         r_ctrl    <= '0;
         r_wr_addr <= '0;
         r_halted  <= 1'b0;
         r_err     <= 1'b0;
         r_err_pc  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         if (w_illegal) begin
            r_valid <= 1'b0;
            if (!r_err) begin
               r_err    <= 1'b1;
               r_err_pc <= in_pc;
            end
         end else begin
            r_valid   <= 1'b1;
            r_instr   <= in_instr;
            r_pc      <= in_pc;
            r_ctrl    <= w_dec;
            r_wr_addr <= w_wr_addr;
            if (w_dec.halt) begin
               r_halted <= 1'b1;
            end
         end
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid   = r_valid;
   assign out_instr   = r_instr;
   assign out_pc      = r_pc;
   assign out_ctrl    = r_ctrl;
   assign out_wr_addr = r_wr_addr;
   assign halted      = r_halted;
   assign err         = r_err;
   assign err_pc      = r_err_pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage. Two instances share the
// stimulus, one with the load-use interlock enabled and one without; an
// instruction-level reference model predicts both every cycle.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_instr;
   logic [15:0] in_pc;
   logic        out_ready;

   logic        rdy [2];
   logic        vld [2];
   logic [15:0] oi  [2];
   logic [15:0] opc [2];
   logic [19:0] oc  [2];
   logic [2:0]  ow  [2];
   logic        hl  [2];
   logic        er  [2];
   logic [15:0] ep  [2];

   int n_checks = 0;
   int n_errors = 0;
   logic armed = 1'b0;

   always #5 clk = ~clk;

   decode_stage #(.INSTR_W(16), .PC_W(16), .HAZARD_EN(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld[0]), .out_ready(out_ready),
      .out_instr(oi[0]), .out_pc(opc[0]), .out_ctrl(oc[0]), .out_wr_addr(ow[0]),
      .halted(hl[0]), .err(er[0]), .err_pc(ep[0]));

   decode_stage #(.INSTR_W(16), .PC_W(16), .HAZARD_EN(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld[1]), .out_ready(out_ready),
      .out_instr(oi[1]), .out_pc(opc[1]), .out_ctrl(oc[1]), .out_wr_addr(ow[1]),
      .halted(hl[1]), .err(er[1]), .err_pc(ep[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference control bundle, built from the instruction-set description
   function automatic logic [19:0] ref_ctrl(input logic [4:0] op);
      int o;
      logic h, j, b, mr, rws, mw, as, rw, se, d1, r7;
      logic [1:0] des, jri;
      o = int'(op);
      {h, j, b, mr, rws, mw, as, rw, se, r7} = '0;
      des = 2'd0; jri = 2'd0; d1 = 1'b1;
      if (o == 0) begin h = 1; d1 = 0; end
      else if (o == 1) d1 = 0;
      else if (o == 4) begin b = 1; jri = 2; se = 1; d1 = 0; end
      else if (o == 5) begin j = 1; as = 1; jri = 1; se = 1; end
      else if (o == 6) begin des = 2; b = 1; rw = 1; jri = 2; se = 1; r7 = 1; d1 = 0; end
      else if (o == 7) begin des = 2; j = 1; as = 1; rw = 1; jri = 1; se = 1; r7 = 1; end
      else if (o == 8 || o == 9) begin des = 1; as = 1; rw = 1; se = 1; end
      else if (o == 10 || o == 11) begin des = 1; as = 1; rw = 1; end
      else if (o >= 12 && o <= 15) begin b = 1; jri = 1; se = 1; end
      else if (o == 16) begin mw = 1; as = 1; se = 1; des = 3; end
      else if (o == 17) begin des = 1; mr = 1; rws = 1; as = 1; rw = 1; se = 1; end
      else if (o == 18) begin des = 3; as = 1; rw = 1; jri = 1; end
      else if (o == 19) begin des = 3; mw = 1; as = 1; rw = 1; se = 1; end
      else if (o >= 20 && o <= 23) begin des = 1; as = 1; rw = 1; jri = 3; end
      else if (o == 24) begin des = 3; as = 1; rw = 1; jri = 1; se = 1; d1 = 0; end
      else if (o == 25 || o == 27 || o >= 28) begin rw = 1; jri = 3; end
      return {h, j, b, mr, rws, mw, as, rw, se, d1, r7, des, jri, op};
   endfunction

   function automatic logic [2:0] ref_dest(input logic [15:0] ins);
      logic [19:0] c;
      c = ref_ctrl(ins[15:11]);
      case (c[8:7])
         2'd0:    return ins[4:2];
         2'd1:    return ins[7:5];
         2'd2:    return 3'd7;
         default: return ins[10:8];
      endcase
   endfunction

   function automatic bit is_illegal(input logic [4:0] op);
      return op == 5'd2 || op == 5'd3 || op == 5'd26;
   endfunction

   // Model state per instance
   logic        m_valid  [2] = '{1'b0, 1'b0};
   logic        m_loaded [2] = '{1'b0, 1'b0};
   logic [15:0] m_instr  [2] = '{16'h0, 16'h0};
   logic [15:0] m_pc     [2] = '{16'h0, 16'h0};
   logic        m_halted [2] = '{1'b0, 1'b0};
   logic        m_err    [2] = '{1'b0, 1'b0};
   logic [15:0] m_errpc  [2] = '{16'h0, 16'h0};
   logic        m_hz     [2] = '{1'b1, 1'b0};

   always @(posedge clk) armed <= 1'b1;

   // Compare against the model mid-cycle, then advance the model past the coming edge
   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < 2; k++) begin
            logic [4:0] op;
            bit rs_used, rt_used, ld_held, stall, exp_rdy;
            logic [2:0] ld_dst;
            op = in_instr[15:11];
            rs_used = !(op == 0 || op == 1 || op == 4 || op == 6 || op == 24);
            rt_used = (op == 26 || op == 27 || op >= 28 || op == 16 || op == 19);
            ld_held = m_valid[k] && m_loaded[k] && (m_instr[k][15:11] == 5'd17);
            ld_dst  = m_instr[k][7:5];
            stall   = m_hz[k] && in_valid === 1'b1 && ld_held &&
                      ((rs_used && in_instr[10:8] == ld_dst) || (rt_used && in_instr[7:5] == ld_dst));
            exp_rdy = rst_n === 1'b1 && !m_halted[k] && !m_err[k] && flush === 1'b0 && !stall &&
                      (!m_valid[k] || out_ready === 1'b1);

            chk($sformatf("d%0d.in_ready", k), 32'(rdy[k]), 32'(exp_rdy));
            chk($sformatf("d%0d.out_valid", k), 32'(vld[k]), 32'(m_valid[k]));
            chk($sformatf("d%0d.out_instr", k), 32'(oi[k]), 32'(m_instr[k]));
            chk($sformatf("d%0d.out_pc", k), 32'(opc[k]), 32'(m_pc[k]));
            chk($sformatf("d%0d.out_ctrl", k), 32'(oc[k]),
                m_loaded[k] ? 32'(ref_ctrl(m_instr[k][15:11])) : 32'd0);
            chk($sformatf("d%0d.out_wr_addr", k), 32'(ow[k]),
                m_loaded[k] ? 32'(ref_dest(m_instr[k])) : 32'd0);
            chk($sformatf("d%0d.halted", k), 32'(hl[k]), 32'(m_halted[k]));
            chk($sformatf("d%0d.err", k), 32'(er[k]), 32'(m_err[k]));
            chk($sformatf("d%0d.err_pc", k), 32'(ep[k]), 32'(m_errpc[k]));

            if (rst_n !== 1'b1) begin
               m_valid[k] = 0; m_loaded[k] = 0; m_instr[k] = '0; m_pc[k] = '0;
               m_halted[k] = 0; m_err[k] = 0; m_errpc[k] = '0;
            end else if (flush === 1'b1) begin
               m_valid[k] = 0;
            end else if (in_valid === 1'b1 && exp_rdy) begin
               if (is_illegal(op)) begin
                  m_valid[k] = 0;
                  m_err[k]   = 1;
                  m_errpc[k] = in_pc;
               end else begin
                  m_valid[k] = 1; m_loaded[k] = 1; m_instr[k] = in_instr; m_pc[k] = in_pc;
                  if (op == 5'd0) m_halted[k] = 1;
               end
            end else if (out_ready === 1'b1) begin
               m_valid[k] = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
      in_valid = v;
      in_instr = ins;
      in_pc    = pc;
   endtask

   initial begin
      logic [15:0] w, last, pc;
      logic [4:0]  o5;
      rst_n = 0; flush = 0; out_ready = 1;
      drive(0, 16'h0000, 16'h0000);
      tick(); tick();
      chk("rst.in_ready", 32'(rdy[0]), 32'd0);
      chk("rst.out_valid", 32'(vld[0]), 32'd0);
      chk("rst.out_ctrl", 32'(oc[0]), 32'd0);

      // ADDI r1 <- r1 + 5
      rst_n = 1;
      drive(1, 16'h4125, 16'h0000);
      tick();
      chk("addi.valid", 32'(vld[0]), 32'd1);
      chk("addi.ctrl", 32'(oc[0]), 32'h03C88);
      chk("addi.wr_addr", 32'(ow[0]), 32'd1);

      // Back-to-back R-type stream
      last = '0;
      for (int i = 0; i < 8; i++) begin
         w = {5'b11011, 3'(i), 3'(i + 1), 3'(i + 2), 2'b00};
         drive(1, w, 16'(2 + 2 * i));
         #1 chk("stream.in_ready", 32'(rdy[0]), 32'd1);
         tick();
         last = w;
      end

      // Downstream backpressure holds the register
      out_ready = 0;
      drive(1, 16'hD800, 16'h0030);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold.instr", 32'(oi[0]), 32'(last));
         chk("hold.in_ready", 32'(rdy[0]), 32'd0);
      end
      out_ready = 1;
      tick();
      drive(0, 16'h0000, 16'h0000);
      tick(); tick();

      // Load-use: LD r2, then ADD r3 <- r2 + r1
      drive(1, 16'h8840, 16'h0040);
      tick();
      drive(1, 16'hDA2C, 16'h0042);
      #1;
      chk("stall.ready_hz", 32'(rdy[0]), 32'd0);
      chk("stall.ready_nohz", 32'(rdy[1]), 32'd1);
      tick();
      #1;
      chk("stall.bubble", 32'(vld[0]), 32'd0);
      chk("stall.nohz_instr", 32'(oi[1]), 32'h0000DA2C);
      chk("stall.ready_after", 32'(rdy[0]), 32'd1);
      tick();
      chk("stall.add_instr", 32'(oi[0]), 32'h0000DA2C);
      chk("stall.add_wr", 32'(ow[0]), 32'd3);
      drive(0, 16'h0000, 16'h0000);
      tick();

      // Flush kills the held entry and blocks the offered one for that cycle
      drive(1, 16'hD804, 16'h0050);
      tick();
      drive(1, 16'hD928, 16'h0052);
      flush = 1;
      tick();
      chk("flush.valid", 32'(vld[0]), 32'd0);
      chk("flush.instr", 32'(oi[0]), 32'h0000D804);
      flush = 0;
      tick();
      chk("flush.resume", 32'(oi[0]), 32'h0000D928);
      drive(0, 16'h0000, 16'h0000);
      tick();

      // Opcode sweep, first with free flow then with random backpressure
      pc = 16'h0100;
      for (int pass = 0; pass < 2; pass++) begin
         for (int op = 1; op < 32; op++) begin
            if (op == 2 || op == 3 || op == 26) continue;
            o5 = 5'(op);
            w = 16'($urandom);
            w[15:11] = o5;
            out_ready = (pass == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            drive(1, w, pc);
            pc = pc + 16'd2;
            tick();
         end
      end
      out_ready = 1;
      drive(0, 16'h0000, 16'h0000);
      tick(); tick();

      // Illegal opcodes: only the first is recorded, neither is delivered
      drive(1, 16'h1000, 16'h0020);
      tick();
      chk("ill.err", 32'(er[0]), 32'd1);
      chk("ill.err_pc", 32'(ep[0]), 32'h20);
      chk("ill.valid", 32'(vld[0]), 32'd0);
      drive(1, 16'h1800, 16'h0022);
      tick();
      chk("ill2.err_pc", 32'(ep[0]), 32'h20);
      chk("ill2.in_ready", 32'(rdy[0]), 32'd0);
      rst_n = 0;
      drive(0, 16'h0000, 16'h0000);
      tick(); tick();
      chk("ill.rst_err", 32'(er[0]), 32'd0);
      chk("ill.rst_err_pc", 32'(ep[0]), 32'd0);

      // HALT is delivered, then the stage refuses input until reset
      rst_n = 1;
      drive(1, 16'h0000, 16'h0010);
      tick();
      chk("halt.valid", 32'(vld[0]), 32'd1);
      chk("halt.ctrl", 32'(oc[0]), 32'h80000);
      chk("halt.halted", 32'(hl[0]), 32'd1);
      drive(1, 16'h4125, 16'h0012);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("halt.in_ready", 32'(rdy[0]), 32'd0);
      end
      chk("halt.drained", 32'(vld[0]), 32'd0);
      rst_n = 0;
      tick();
      rst_n = 1;
      drive(1, 16'h4125, 16'h0060);
      #1 chk("halt.rst_ready", 32'(rdy[0]), 32'd1);
      tick();
      chk("halt.resume_pc", 32'(opc[0]), 32'h60);

      // Reserved hole inside the 1101x group
      drive(1, 16'hD000, 16'h0070);
      tick();
      chk("ill26.err_pc", 32'(ep[0]), 32'h70);
      drive(0, 16'h0000, 16'h0000);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
